// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle shared by the requesters, the round-robin arbiter and the FIFO write port.
// The master modport is the arbiter's view; the slave modport is the requester/FIFO view.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 12
);
    logic [NUM_REQ-1:0]           src_valid;
    logic [NUM_REQ*DATA_SIZE-1:0] src_data;
    logic [NUM_REQ-1:0]           src_ready;
    logic [NUM_REQ-1:0]           gnt;
    logic                         wFull;
    logic                         winc;
    logic [DATA_SIZE-1:0]         wData;

    modport master (
        input  src_valid, src_data, wFull,
        output src_ready, gnt, winc, wData
    );

    modport slave (
        output src_valid, src_data, wFull,
        input  src_ready, gnt, winc, wData
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: grants one requester a bounded burst into the FIFO write port.
// Optional macro FIFO_WR_ARB_STATS_EN adds stall_cnt / burst_cnt statistic outputs.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 12,
    parameter int MAX_BURST = 8
) (
    input  logic              wclk,
    input  logic              wrst,
    fifo_wr_arbiter_if.master bus
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       burst_cnt
`endif
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {ARB, BURST} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [DATA_SIZE-1:0] masked_data [NUM_REQ];
    logic [DATA_SIZE-1:0] sel_data;
    logic                 g_valid;
    logic                 xfer;
    logic                 burst_end;
    logic                 any_valid;
    logic [PTR_W-1:0]     pick;
    logic [PTR_W:0]       scan_idx;
    logic                 pick_found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign masked_data[gi] = gnt_q[gi] ? bus.src_data[gi*DATA_SIZE +: DATA_SIZE] : '0;
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_data = sel_data | masked_data[i];
        end
    end

    assign g_valid   = |(bus.src_valid & gnt_q);
    assign xfer      = g_valid & ~bus.wFull;
    assign any_valid = |bus.src_valid;
    // A dropped valid ends the burst even while the FIFO is full.
    assign burst_end = (state_q == BURST) &&
                       (!g_valid || (xfer && (int'(beat_cnt_q) + 1 == MAX_BURST)));

    // Scan rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ (not necessarily a power of two).
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        scan_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (scan_idx >= (PTR_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (PTR_W+1)'(NUM_REQ);
            end
            if (!pick_found && bus.src_valid[scan_idx[PTR_W-1:0]]) begin
                pick_found = 1'b1;
                pick       = scan_idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ARB: begin
                gnt_d = '0;
                if (any_valid) begin
                    state_d     = BURST;
                    gnt_d[pick] = 1'b1;
                    beat_cnt_d  = '0;
                    rr_ptr_d    = (pick == PTR_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                end
            end
            BURST: begin
                if (burst_end) begin
                    state_d    = ARB;
                    gnt_d      = '0;
                    beat_cnt_d = '0;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q    <= ARB;
            gnt_q      <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.src_ready = gnt_q & {NUM_REQ{~bus.wFull}};
    assign bus.winc      = xfer;
    assign bus.wData     = sel_data;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] burst_cnt_q, burst_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        burst_cnt_d = burst_cnt_q;
        if (state_q == BURST && g_valid && bus.wFull && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (burst_end) begin
            burst_cnt_d = burst_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            stall_cnt_q <= '0;
            burst_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign burst_cnt = burst_cnt_q;
`endif

    a_gnt_onehot0 : assert property (@(posedge wclk) disable iff (wrst) $onehot0(gnt_q));
    a_winc_not_full : assert property (@(posedge wclk) disable iff (wrst) bus.winc |-> !bus.wFull);
    a_ready_onehot0 : assert property (@(posedge wclk) disable iff (wrst) $onehot0(bus.src_ready));
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a cycle-by-cycle vector table plus burst, fairness,
// stall and mid-burst reset sequences. Stats outputs are checked when FIFO_WR_ARB_STATS_EN is set.
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DS = 12;
    localparam int MB = 8;
    localparam int NV = 17;

    logic clk  = 1'b0;
    logic wrst = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_SIZE(DS)) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] burst_cnt;
`endif

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_SIZE(DS), .MAX_BURST(MB)) dut (
        .wclk(clk),
        .wrst(wrst),
        .bus (bus)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stall_cnt(stall_cnt),
        .burst_cnt(burst_cnt)
`endif
    );

    typedef struct {
        logic [NR-1:0] valid;
        logic          full;
        logic [NR-1:0] exp_gnt;
        logic [NR-1:0] exp_ready;
        logic          exp_winc;
        logic [DS-1:0] exp_wdata;
    } vec_t;

    vec_t vecs [NV];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tags();
        for (int i = 0; i < NR; i++) begin
            bus.src_data[i*DS +: DS] = 12'(12'hA00 + i);
        end
    endtask

    task automatic do_reset();
        wrst = 1'b1;
        bus.src_valid = '0;
        bus.wFull = 1'b0;
        next_cycle();
        next_cycle();
        wrst = 1'b0;
    endtask

    initial begin
        int beat, len, gap, stalls, bad, cur, leak;
        int lens[$];
        int cnts[$];
        logic [NR-1:0] order[$];
        logic [NR-1:0] prev_g;
        logic ended;

        // valid, full, gnt, ready, winc, wData  (requester i data = A0i)
        vecs[0]  = '{4'b1000, 1'b0, 4'b0000, 4'b0000, 1'b0, 12'h000};
        vecs[1]  = '{4'b1001, 1'b0, 4'b1000, 4'b1000, 1'b1, 12'hA03};
        vecs[2]  = '{4'b1001, 1'b0, 4'b1000, 4'b1000, 1'b1, 12'hA03};
        vecs[3]  = '{4'b0001, 1'b0, 4'b1000, 4'b1000, 1'b0, 12'hA03};
        vecs[4]  = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 12'h000};
        vecs[5]  = '{4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 12'hA00};
        vecs[6]  = '{4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b0, 12'hA00};
        vecs[7]  = '{4'b0000, 1'b1, 4'b0001, 4'b0000, 1'b0, 12'hA00};
        vecs[8]  = '{4'b0110, 1'b0, 4'b0000, 4'b0000, 1'b0, 12'h000};
        vecs[9]  = '{4'b0110, 1'b0, 4'b0010, 4'b0010, 1'b1, 12'hA01};
        vecs[10] = '{4'b0110, 1'b1, 4'b0010, 4'b0000, 1'b0, 12'hA01};
        vecs[11] = '{4'b0100, 1'b0, 4'b0010, 4'b0010, 1'b0, 12'hA01};
        vecs[12] = '{4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0, 12'h000};
        vecs[13] = '{4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 12'hA02};
        vecs[14] = '{4'b0000, 1'b0, 4'b0100, 4'b0100, 1'b0, 12'hA02};
        vecs[15] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 12'h000};
        vecs[16] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 12'h000};

        // Reset state, with every requester valid so a leak would show.
        set_tags();
        wrst = 1'b1;
        bus.src_valid = 4'b1111;
        bus.wFull = 1'b0;
        next_cycle();
        next_cycle();
        #4;
        check("rst_gnt", bus.gnt, 4'b0000);
        check("rst_ready", bus.src_ready, 4'b0000);
        check("rst_winc", bus.winc, 1'b0);
        check("rst_wdata", bus.wData, 12'h000);
`ifdef FIFO_WR_ARB_STATS_EN
        check("rst_stall_cnt", stall_cnt, 16'd0);
        check("rst_burst_cnt", burst_cnt, 16'd0);
`endif
        $display("reset: gnt=%b ready=%b winc=%b wData=%h", bus.gnt, bus.src_ready, bus.winc, bus.wData);
        next_cycle();

        // Table: valid drop mid-burst, rr_ptr wrap, stall and drop-while-full.
        do_reset();
        set_tags();
        for (int k = 0; k < NV; k++) begin
            bus.src_valid = vecs[k].valid;
            bus.wFull = vecs[k].full;
            #4;
            check($sformatf("vec%0d", k),
                  {bus.gnt, bus.src_ready, bus.winc, bus.wData},
                  {vecs[k].exp_gnt, vecs[k].exp_ready, vecs[k].exp_winc, vecs[k].exp_wdata});
            $display("vec %0d: valid=%b full=%b gnt=%b ready=%b winc=%b wData=%h",
                     k, bus.src_valid, bus.wFull, bus.gnt, bus.src_ready, bus.winc, bus.wData);
            next_cycle();
        end

        // Single requester 1 sending 20 beats: bursts of 8, 8, 4 with one bubble each.
        do_reset();
        beat = 0; len = 0; gap = 0;
        bus.src_valid = 4'b0010;
        bus.src_data[DS +: DS] = 12'h100;
        #4;
        check("lat0_gnt", bus.gnt, 4'b0000);
        next_cycle();
        for (int c = 0; c < 60; c++) begin
            bus.src_valid = (beat < 20) ? 4'b0010 : 4'b0000;
            bus.src_data[DS +: DS] = 12'(12'h100 + beat);
            #4;
            if (c == 0) check("lat1_gnt", bus.gnt, 4'b0010);
            if (bus.winc) begin
                check($sformatf("beat%0d_data", beat), bus.wData, 12'(12'h100 + beat));
                if (gap > 0) begin
                    check("bubble_len", gap, 1);
                    gap = 0;
                end
                beat++;
                len++;
            end else if (bus.gnt == 4'b0000) begin
                if (len > 0) begin
                    lens.push_back(len);
                    $display("single: burst of %0d beats, total %0d", len, beat);
                    len = 0;
                end
                if (beat > 0 && beat < 20) gap++;
            end
            next_cycle();
        end
        check("single_beats", beat, 20);
        check("single_nbursts", lens.size(), 3);
        if (lens.size() == 3) begin
            check("single_b0", lens[0], 8);
            check("single_b1", lens[1], 8);
            check("single_b2", lens[2], 4);
        end

        // All four valid from reset: grant order 0,1,2,3,0, eight beats each.
        do_reset();
        bus.src_valid = 4'b1111;
        prev_g = '0; cur = 0; leak = 0;
        for (int c = 0; c < 100 && order.size() < 5; c++) begin
            #4;
            if ((bus.src_ready & ~bus.gnt) != 4'b0000) leak++;
            if (bus.gnt != 4'b0000 && prev_g == 4'b0000) order.push_back(bus.gnt);
            if (bus.gnt == 4'b0000 && prev_g != 4'b0000) begin
                cnts.push_back(cur);
                $display("fair: grant %b wrote %0d beats", prev_g, cur);
                cur = 0;
            end
            if (bus.winc) cur++;
            prev_g = bus.gnt;
            next_cycle();
        end
        check("fair_ngrants", order.size(), 5);
        check("fair_nbursts", cnts.size(), 4);
        if (order.size() == 5 && cnts.size() == 4) begin
            check("fair_g0", order[0], 4'b0001);
            check("fair_g1", order[1], 4'b0010);
            check("fair_g2", order[2], 4'b0100);
            check("fair_g3", order[3], 4'b1000);
            check("fair_g4", order[4], 4'b0001);
            for (int i = 0; i < 4; i++) check($sformatf("fair_cnt%0d", i), cnts[i], 8);
        end
        check("fair_ready_leak", leak, 0);

        // Requester 2 stalled by wFull for 5 cycles after its third beat.
        do_reset();
        bus.src_valid = 4'b0100;
        beat = 0; stalls = 0; bad = 0; ended = 1'b0;
        for (int c = 0; c < 60 && !ended; c++) begin
            bus.wFull = (beat == 3 && stalls < 5);
            #4;
            if (bus.wFull) begin
                stalls++;
                if (bus.winc || bus.src_ready[2] || bus.gnt != 4'b0100) bad++;
            end
            if (bus.winc) beat++;
            if (beat > 0 && bus.gnt == 4'b0000) ended = 1'b1;
            next_cycle();
        end
        bus.wFull = 1'b0;
        $display("stall: %0d stall cycles, %0d beats, %0d bad stall cycles", stalls, beat, bad);
        check("stall_cycles", stalls, 5);
        check("stall_bad", bad, 0);
        check("stall_beats", beat, 8);
`ifdef FIFO_WR_ARB_STATS_EN
        check("stall_cnt", stall_cnt, 16'd5);
        check("burst_cnt", burst_cnt, 16'd1);
`endif

        // wrst pulse at beat 4 of the first burst; next grant goes back to requester 0.
        do_reset();
        bus.src_valid = 4'b1111;
        beat = 0;
        for (int c = 0; c < 40 && beat < 4; c++) begin
            #4;
            if (bus.winc) beat++;
            next_cycle();
        end
        check("mid_beats", beat, 4);
        wrst = 1'b1;
        #4;
        next_cycle();
        wrst = 1'b0;
        #4;
        check("mid_rst_out", {bus.gnt, bus.src_ready, bus.winc}, 9'b0);
        next_cycle();
        #4;
        check("mid_regrant", bus.gnt, 4'b0001);
        $display("midreset: regrant gnt=%b", bus.gnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
